// File: rtl/gray_ptr_pkg.sv
// gray_ptr_pkg: shared helpers for the Gray pointer synchroniser.
// Gray/binary conversion, hamming check and stage-count limits.
package gray_ptr_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int MAXW       = 32;

    // Values narrower than MAXW are zero-extended by the caller;
    // leading zeros convert to leading zeros, so the width is implicit.
    function automatic logic [MAXW-1:0] gray2bin(
        input logic [MAXW-1:0] g
    );
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAXW-1:0] bin2gray(
        input logic [MAXW-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // True when more than one bit of x is set.
    function automatic logic popcount_gt1(
        input logic [MAXW-1:0] x
    );
        return (x & (x - 32'd1)) != '0;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_chain.sv
// sync_chain: DEPTH-deep flop chain for an asynchronous bus.
// Only place carrying async-reg attributes.
module sync_chain #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    (* ASYNC_REG = "TRUE", keep = "true" *)
    logic [W-1:0] r_stage [DEPTH];

    // Shift the source value through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: Gray pointer synchroniser with binary, delta and strobe.
// Define GRAY_PTR_SYNC_CHECK_EN to reject multi-bit jumps and flag err.
module gray_ptr_sync
    import gray_ptr_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WIDTH:0] d_in,
    output logic [WIDTH:0] q_gray,
    output logic [WIDTH:0] q_bin,
    output logic [WIDTH:0] delta,
    output logic           chg,
    output logic           err
);

    localparam int PW = WIDTH + 1;

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be within 2..4");
    end
    if (PW > MAXW) begin : g_bad_width
        $error("gray_ptr_sync: pointer wider than helper functions");
    end

    logic [PW-1:0] w_q_gray;
    logic [PW-1:0] w_bin;
    logic          w_diff;
    logic          w_accept;

    logic [PW-1:0] r_acc_gray;
    logic [PW-1:0] r_q_bin;
    logic [PW-1:0] r_delta;
    logic          r_chg;

    sync_chain #(
        .W     (PW),
        .DEPTH (STAGES)
    ) u_chain (
        .clk (clk),
        .rst (rst),
        .i_d (d_in),
        .o_q (w_q_gray)
    );

    assign w_bin  = PW'(gray2bin(MAXW'(w_q_gray)));
    assign w_diff = (w_q_gray != r_acc_gray);

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic w_bad;
    logic r_err;

    assign w_bad    = popcount_gt1(MAXW'(w_q_gray ^ r_acc_gray));
    assign w_accept = w_diff & ~w_bad;

    // Sticky flag for any rejected multi-bit transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_diff && w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_accept = w_diff;
    assign err      = 1'b0;
`endif

    // Accept a new Gray value: update binary, delta and one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_gray <= '0;
            r_q_bin    <= '0;
            r_delta    <= '0;
            r_chg      <= 1'b0;
        end else begin
            r_chg <= w_accept;
            if (w_accept) begin
                r_acc_gray <= w_q_gray;
                r_q_bin    <= w_bin;
                r_delta    <= w_bin - r_q_bin;
            end else begin
                r_delta    <= '0;
            end
        end
    end

    assign q_gray = w_q_gray;
    assign q_bin  = r_q_bin;
    assign delta  = r_delta;
    assign chg    = r_chg;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: scoreboard bench for gray_ptr_sync.
// Directed phases followed by a randomized pointer walk.
module tb_gray_ptr_sync;

    localparam int W  = 3;
    localparam int S  = 2;
    localparam int PW = W + 1;
    localparam int N  = 1 << PW;
`ifdef GRAY_PTR_SYNC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [PW-1:0] g;
        logic [PW-1:0] b;
        logic [PW-1:0] d;
        logic          c;
        logic          e;
    } cyc_t;

    typedef struct packed {
        logic [PW-1:0] b;
        logic [PW-1:0] d;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] d_in = '0;
    logic [PW-1:0] q_gray, q_bin, delta;
    logic          chg, err;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    cyc_t cq[$];
    ev_t  eq[$];

    // Reference state: pipeline of sampled inputs plus accepted value.
    logic [PW-1:0] m_pipe[$];
    int            m_acc;
    logic          m_err;

    gray_ptr_sync #(.WIDTH(W), .STAGES(S)) dut (
        .clk    (clk),
        .rst    (rst),
        .d_in   (d_in),
        .q_gray (q_gray),
        .q_bin  (q_bin),
        .delta  (delta),
        .chg    (chg),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gray_of(input int v);
        int m;
        m = v % N;
        return PW'(m ^ (m >> 1));
    endfunction

    function automatic int bin_of(input logic [PW-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (gray_of(i) == g) return i;
        end
        return -1;
    endfunction

    function automatic int hamming(input logic [PW-1:0] x);
        int c;
        c = 0;
        for (int i = 0; i < PW; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < S; i++) m_pipe.push_back('0);
        m_acc = 0;
        m_err = 1'b0;
    endtask

    // One destination edge with rst/d_in as driven before it.
    task automatic step(input logic r, input logic [PW-1:0] d);
        cyc_t x;
        logic [PW-1:0] g_old;
        @(negedge clk);
        rst  = r;
        d_in = d;
        @(posedge clk);
        x.c = 1'b0;
        x.d = '0;
        if (r) begin
            model_reset();
        end else begin
            g_old = m_pipe[0];
            if (g_old != gray_of(m_acc)) begin
                if (CHK && hamming(g_old ^ gray_of(m_acc)) > 1) begin
                    m_err = 1'b1;
                end else begin
                    x.c = 1'b1;
                    x.d = PW'((bin_of(g_old) - m_acc + N) % N);
                    m_acc = bin_of(g_old);
                end
            end
            m_pipe.push_back(d);
            void'(m_pipe.pop_front());
        end
        x.g = m_pipe[0];
        x.b = PW'(m_acc);
        x.e = m_err;
        cq.push_back(x);
        if (x.c) eq.push_back('{b: x.b, d: x.d});
    endtask

    task automatic hold(input logic [PW-1:0] d, input int n);
        for (int i = 0; i < n; i++) step(1'b0, d);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: per-cycle checks plus event pop on every strobe.
    initial begin
        cyc_t x;
        ev_t  v;
        while (!done) begin
            @(posedge clk);
            #2;
            if (cq.size() != 0) begin
                x = cq.pop_front();
                chk("q_gray", int'(q_gray), int'(x.g));
                chk("q_bin",  int'(q_bin),  int'(x.b));
                chk("delta",  int'(delta),  int'(x.d));
                chk("chg",    int'(chg),    int'(x.c));
                chk("err",    int'(err),    int'(x.e));
            end
            if (chg === 1'b1) begin
                if (eq.size() == 0) begin
                    chk("unexpected_chg", 1, 0);
                end else begin
                    v = eq.pop_front();
                    chk("ev_q_bin", int'(q_bin), int'(v.b));
                    chk("ev_delta", int'(delta), int'(v.d));
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int p;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0110);
        hold('0, 3);
        hold(gray_of(1), 5);
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 2; i <= N + 1; i++) hold(gray_of(i), 1);
        end
        hold(gray_of(1), 5);
        hold(gray_of(3), 5);
        hold(gray_of(2), 5);
        step(1'b1, '0);
        hold('0, 3);
        for (int i = 1; i <= 9; i++) hold(gray_of(i), 1);
        hold(gray_of(9), 4);
        hold(gray_of(10), 1);
        step(1'b1, gray_of(10));
        hold(gray_of(1), 5);
        step(1'b1, '0);
        p = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                p = 0;
                step(1'b1, gray_of($urandom_range(0, N - 1)));
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2: p = p;
                    9:       p = p + $urandom_range(2, 3);
                    default: p = p + 1;
                endcase
                step(1'b0, gray_of(p));
            end
        end
        hold(gray_of(p), S + 3);
        @(posedge clk);
        #3;
        done = 1'b1;
        chk("events_drained", eq.size(), 0);
        chk("cycles_drained", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: still running, expected finish");
        $fatal(1);
    end

endmodule
